mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle unsigned multiplier (start/busy/valid handshake, WIDTH-bit result) among NUM_REQ requesters. It sits between the requesting units (e.g. ALU issue ports, filter engines) and the multiplier. It latches each winner's operands, pulses the multiplier start, and tracks the multiplier's busy/valid protocol. It returns the result to the winner with a one-hot done pulse.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 24, operand/result width; must match multiplier WIDTH
- TIMEOUT, 64, watchdog limit in cycles (used only with MUL_ARB_TIMEOUT_EN)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  request level per requester; held high with stable operands until grant
- rs1_flat  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- rs2_flat  in  NUM_REQ*WIDTH  operand B, same packing
- grant  out  NUM_REQ  one-hot, 1-cycle pulse: operands latched
- done  out  NUM_REQ  one-hot, 1-cycle pulse: result valid this cycle
- result  out  WIDTH  product returned with done
- err  out  1  high with done when the operation timed out
- arb_busy  out  1  high whenever state != IDLE
- mul_rs1, mul_rs2  out  WIDTH  operands to multiplier, held stable from ISSUE until next grant
- mul_start  out  1  start pulse to multiplier
- mul_result  in  WIDTH  multiplier result
- mul_valid  in  1  multiplier valid (sticky until next start)
- mul_busy  in  1  multiplier busy

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if any req, select winner by round-robin starting at last_grant+1 (mod NUM_REQ). At the edge: grant[w]=1, mul_start=1, operands latched into mul_rs1/mul_rs2, last_grant=w, go to ISSUE.
- ISSUE: one cycle. At the next edge grant=0, mul_start=0, go to WAIT_BUSY.
- WAIT_BUSY: wait for mul_busy=1, then go to WAIT_DONE. mul_valid is ignored here because it is sticky from the previous operation.
- WAIT_DONE: when mul_valid=1 and mul_busy=0, register result=mul_result, done[w]=1, err=0, go to RESP.
- RESP: one cycle with done pulse. At the next edge done=0, go to IDLE.
- A requester keeping req high after its grant is treated as a new request. Round-robin fairness means it is served only after other pending requesters.
- req changes outside IDLE are ignored. Requests arriving in the same cycle are resolved purely by the rotating priority.
- Reset: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has top priority), grant=0, done=0, result=0, err=0, arb_busy=0, mul_start=0, mul_rs1=0, mul_rs2=0.
- Reset mid-operation abandons the transaction and no done is issued. The multiplier shares rst.

## Timing
- req sampled in cycle 0 → grant and mul_start high in cycle 1 (registered, exactly 1 cycle).
- The multiplier registers start internally, so mul_busy rises 2 edges after mul_start is first seen.
- Overhead outside multiplier compute: 1 (grant/issue) + 1 (RESP) cycles. No back-to-back grant: at least 1 IDLE cycle between done and the next grant.
- result and err hold their values until the next done.

## Configuration
- MUL_ARB_TIMEOUT_EN defined:
  - A counter runs during WAIT_BUSY and WAIT_DONE and clears on ISSUE.
  - When it reaches TIMEOUT, go to RESP with done[w]=1, err=1, result=0.
  - No further start is issued to the stalled multiplier until mul_busy=0 is seen in IDLE.
- Not defined:
  - No counter. The arbiter waits indefinitely.
  - err is tied to 0.

## Test plan
- Single request: req[2]=1, rs1=0x000003, rs2=0x000005 → grant[2] 1 cycle later, one mul_start pulse, done[2] with result=0x00000F, err=0.
- Simultaneous req=4'b1111 after reset → grants in order 0,1,2,3. Each done matches its own operands. Exactly one mul_start per grant.
- Requester 1 holds req permanently while req[3] pulses → grants alternate 1,3,1,3, with no starvation.
- Back-to-back on same requester, where the sticky mul_valid=1 is left from the previous op → no early done. done comes only after mul_busy rises and falls.
- rst asserted during WAIT_DONE → all outputs 0 on the same cycle, state IDLE. No done for the abandoned op. The next request is served normally.
- With MUL_ARB_TIMEOUT_EN, TIMEOUT=16, and the multiplier model holding mul_busy=0 → done[w] and err=1 exactly 16 cycles after entering WAIT_BUSY, with result=0.

Source files
------------

// File: rtl/mul_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter/sequencer sharing one multi-cycle multiplier among NUM_REQ requesters.
// Optional watchdog with error completion is enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   rs1_flat,
    input  logic [NUM_REQ*WIDTH-1:0]   rs2_flat,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           result,
    output logic                       err,
    output logic                       arb_busy,
    output logic [WIDTH-1:0]           mul_rs1,
    output logic [WIDTH-1:0]           mul_rs2,
    output logic                       mul_start,
    input  logic [WIDTH-1:0]           mul_result,
    input  logic                       mul_valid,
    input  logic                       mul_busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     mul_rs1_q, mul_rs1_d;
    logic [WIDTH-1:0]     mul_rs2_q, mul_rs2_d;
    logic                 mul_start_q, mul_start_d;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [IW-1:0]        owner_q, owner_d;

    logic                 hi_found, lo_found, win_found;
    logic [IW-1:0]        hi_idx, lo_idx, win_idx;
    logic [WIDTH-1:0]     sel_rs1, sel_rs2;
    logic [NUM_REQ-1:0]   win_onehot, owner_onehot;
    logic                 can_issue;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 stall_q, stall_d;
    logic                 err_q, err_d;
`endif

    // Rotating priority: lowest requester above last_grant wins, else wrap to the lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) > last_grant_q)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
            if (req[i] && (IW'(i) <= last_grant_q)) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_rs1 = rs1_flat[i*WIDTH +: WIDTH];
                sel_rs2 = rs2_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    assign win_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

`ifdef MUL_ARB_TIMEOUT_EN
    // After a timeout the multiplier may still be computing; hold off until it reports idle.
    assign can_issue = !stall_q || !mul_busy;
`else
    assign can_issue = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = '0;
        done_d       = '0;
        mul_start_d  = 1'b0;
        result_d     = result_q;
        mul_rs1_d    = mul_rs1_q;
        mul_rs2_d    = mul_rs2_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        stall_d      = stall_q;
        err_d        = err_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef MUL_ARB_TIMEOUT_EN
                if (!mul_busy) begin
                    stall_d = 1'b0;
                end
`endif
                if (win_found && can_issue) begin
                    grant_d      = win_onehot;
                    mul_start_d  = 1'b1;
                    mul_rs1_d    = sel_rs1;
                    mul_rs2_d    = sel_rs2;
                    last_grant_d = win_idx;
                    owner_d      = win_idx;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef MUL_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_WAIT_BUSY;
            end
            // mul_valid is still sticky from the previous op here, so only busy matters.
            S_WAIT_BUSY: begin
                if (mul_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mul_valid && !mul_busy) begin
                    result_d = mul_result;
                    done_d   = owner_onehot;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MUL_ARB_TIMEOUT_EN
        if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(TIMEOUT - 1) && state_d != S_RESP) begin
                result_d = '0;
                done_d   = owner_onehot;
                err_d    = 1'b1;
                stall_d  = 1'b1;
                state_d  = S_RESP;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            result_q     <= '0;
            mul_rs1_q    <= '0;
            mul_rs2_q    <= '0;
            mul_start_q  <= 1'b0;
            last_grant_q <= IW'(NUM_REQ - 1);
            owner_q      <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            result_q     <= result_d;
            mul_rs1_q    <= mul_rs1_d;
            mul_rs2_q    <= mul_rs2_d;
            mul_start_q  <= mul_start_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            err_q        <= err_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign result    = result_q;
    assign mul_rs1   = mul_rs1_q;
    assign mul_rs2   = mul_rs2_q;
    assign mul_start = mul_start_q;
    assign arb_busy  = (state_q != S_IDLE);
`ifdef MUL_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mul_arbiter with a behavioural start/busy/valid multiplier model.
module tb_mul_arbiter;
    localparam int NR  = 4;
    localparam int W   = 24;
    localparam int TO  = 16;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   rs1_flat, rs2_flat;
    logic [NR-1:0]     grant, done;
    logic [W-1:0]      result, mul_rs1, mul_rs2, mul_result;
    logic              err, arb_busy, mul_start, mul_valid, mul_busy;

    mul_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .rs1_flat(rs1_flat), .rs2_flat(rs2_flat),
        .grant(grant), .done(done), .result(result), .err(err), .arb_busy(arb_busy),
        .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_start(mul_start),
        .mul_result(mul_result), .mul_valid(mul_valid), .mul_busy(mul_busy)
    );

    always #5 clk = ~clk;

    // multiplier model: start registered, busy for LAT cycles, sticky valid
    logic            m_st_q, stall_mode;
    logic [2*W-1:0]  m_prod;
    int              m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st_q <= 1'b0; mul_busy <= 1'b0; mul_valid <= 1'b0;
            mul_result <= '0; m_prod <= '0; m_cnt <= 0;
        end else begin
            m_st_q <= mul_start && !stall_mode;
            if (m_st_q) begin
                mul_busy  <= 1'b1;
                mul_valid <= 1'b0;
                m_cnt     <= LAT;
                m_prod    <= mul_rs1 * mul_rs2;
            end else if (mul_busy) begin
                if (m_cnt == 1) begin
                    mul_busy   <= 1'b0;
                    mul_valid  <= 1'b1;
                    mul_result <= m_prod[W-1:0];
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int n_vec = 0, n_err = 0, n_start = 0, n_done = 0;
    always @(negedge clk) begin
        if (mul_start) n_start++;
        if (|done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        rs1_flat[i*W +: W] = a;
        rs2_flat[i*W +: W] = b;
    endtask

    task automatic wait_grant(input string tag, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (grant == '0 && cyc < 40);
        check({tag, "_grant_seen"}, 64'(|grant), 1);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (done == '0 && cyc < 60);
        check({tag, "_done_seen"}, 64'(|done), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int c, s0, d0;
    int seq3 [4] = '{1, 3, 1, 3};
    logic [W-1:0] exp2 [4] = '{24'h000022, 24'h004E6F, 24'hFFFFFF, 24'hFFFFFE};

    initial begin
        rst = 1'b1; req = '0; rs1_flat = '0; rs2_flat = '0; stall_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_rs1", mul_rs1, 0);
        check("rst_mul_rs2", mul_rs2, 0);
        rst = 1'b0;
        @(negedge clk);

        // single request
        set_ops(2, 24'h000003, 24'h000005);
        s0 = n_start;
        req = 4'b0100;
        wait_grant("t1", c);
        check("t1_grant", grant, 4'b0100);
        check("t1_grant_lat", c, 1);
        check("t1_mul_start", mul_start, 1);
        check("t1_mul_rs1", mul_rs1, 3);
        check("t1_mul_rs2", mul_rs2, 5);
        check("t1_arb_busy", arb_busy, 1);
        req = '0;
        wait_done("t1", c);
        check("t1_done", done, 4'b0100);
        check("t1_result", result, 24'h00000F);
        check("t1_err", err, 0);
        check("t1_starts", n_start - s0, 1);

        // all four at once after reset: 0,1,2,3
        do_reset();
        set_ops(0, 24'h000011, 24'h000002);
        set_ops(1, 24'h000123, 24'h000045);
        set_ops(2, 24'h000FFF, 24'h001001);
        set_ops(3, 24'hFFFFFF, 24'h000002);
        s0 = n_start;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant("t2", c);
            check("t2_grant", grant, 4'b0001 << k);
            req[k] = 1'b0;
            wait_done("t2", c);
            check("t2_done", done, 4'b0001 << k);
            check("t2_result", result, exp2[k]);
        end
        check("t2_starts", n_start - s0, 4);

        // requester 1 holds req, requester 3 pulses
        set_ops(1, 24'h000007, 24'h000009);
        set_ops(3, 24'h000100, 24'h000100);
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            wait_grant("t3", c);
            check("t3_grant", grant, 4'b0001 << seq3[k]);
            req[3] = (seq3[k] == 1);
            wait_done("t3", c);
            check("t3_done", done, 4'b0001 << seq3[k]);
            check("t3_result", result, (seq3[k] == 1) ? 24'h00003F : 24'h010000);
        end
        req = '0;
        @(negedge clk);

        // back-to-back on requester 0 with sticky valid left over
        set_ops(0, 24'h000006, 24'h000007);
        req = 4'b0001;
        wait_grant("t4a", c);
        check("t4a_grant", grant, 4'b0001);
        check("t4a_sticky_valid", mul_valid, 1);
        wait_done("t4a", c);
        check("t4a_latency", c, 3 + LAT);
        check("t4a_result", result, 24'h00002A);
        set_ops(0, 24'h000800, 24'h000800);
        wait_grant("t4b", c);
        check("t4b_gap", c, 2);
        check("t4b_grant", grant, 4'b0001);
        req = '0;
        wait_done("t4b", c);
        check("t4b_latency", c, 3 + LAT);
        check("t4b_result", result, 24'h400000);

        // reset while in WAIT_DONE
        set_ops(2, 24'h000002, 24'h000003);
        req = 4'b0100;
        wait_grant("t5", c);
        req = '0;
        repeat (4) @(negedge clk);
        check("t5_pre_busy", mul_busy, 1);
        check("t5_pre_arb_busy", arb_busy, 1);
        rst = 1'b1;
        #1;
        check("t5_grant", grant, 0);
        check("t5_done", done, 0);
        check("t5_result", result, 0);
        check("t5_err", err, 0);
        check("t5_arb_busy", arb_busy, 0);
        check("t5_mul_start", mul_start, 0);
        check("t5_mul_rs1", mul_rs1, 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (10) @(negedge clk);
        check("t5_no_done", n_done - d0, 0);
        set_ops(2, 24'h00000A, 24'h00000B);
        req = 4'b0100;
        wait_grant("t5b", c);
        check("t5b_grant", grant, 4'b0100);
        req = '0;
        wait_done("t5b", c);
        check("t5b_done", done, 4'b0100);
        check("t5b_result", result, 24'h00006E);

`ifdef MUL_ARB_TIMEOUT_EN
        // multiplier never goes busy: watchdog completes with err
        stall_mode = 1'b1;
        set_ops(0, 24'h000005, 24'h000005);
        req = 4'b0001;
        wait_grant("t6", c);
        req = '0;
        wait_done("t6", c);
        check("t6_latency", c, TO + 1);
        check("t6_done", done, 4'b0001);
        check("t6_err", err, 1);
        check("t6_result", result, 0);
        stall_mode = 1'b0;
        @(negedge clk);
        set_ops(1, 24'h000003, 24'h000003);
        req = 4'b0010;
        wait_grant("t6b", c);
        check("t6b_grant", grant, 4'b0010);
        req = '0;
        wait_done("t6b", c);
        check("t6b_result", result, 24'h000009);
        check("t6b_err", err, 0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
